tiny_soc_mem_ctrl: RTL and testbench

TINY_SOC_MEM_CTRL -- requirements
Module: tiny_soc_mem_ctrl

---
 rtl/tiny_soc_mem_ctrl_if.sv | 33 +++
 rtl/tiny_soc_mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_tiny_soc_mem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_soc_mem_ctrl_if.sv
// rtl/tiny_soc_mem_ctrl_if.sv - multi-port request/response bus bundle for tiny_soc_mem_ctrl
//
// Signals (one bit or lane per requester unless noted):
//   req_i, we_i, addr_i, be_i, wdata_i : request side, driven by the requesters
//   gnt_o                              : one-hot grant, combinational
//   rvalid_o, err_o                    : per-port response valid / error
//   rdata_o                            : shared read data, qualified by rvalid_o
// Modports: master (requesters), slave (memory controller).
interface tiny_soc_mem_ctrl_if #(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64
);
    logic [NumPorts-1:0]             req_i;
    logic [NumPorts-1:0]             we_i;
    logic [NumPorts*AddrWidth-1:0]   addr_i;
    logic [NumPorts*DataWidth/8-1:0] be_i;
    logic [NumPorts*DataWidth-1:0]   wdata_i;
    logic [NumPorts-1:0]             gnt_o;
    logic [NumPorts-1:0]             rvalid_o;
    logic [NumPorts-1:0]             err_o;
    logic [DataWidth-1:0]            rdata_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o
    );
endinterface

// File: rtl/tiny_soc_mem_ctrl.sv
// rtl/tiny_soc_mem_ctrl.sv - round-robin multi-port SRAM controller with optional MMIO stop register
//
// Ports:
//   clk_i        : single clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   bus          : tiny_soc_mem_ctrl_if.slave request/response bundle
//   stop_valid_o : end-of-benchmark write seen (sticky until reset)
//   stop_code_o  : low 32 bits of the first stop write
// Optional feature: define TINY_SOC_MMIO_STOP_EN to decode writes to StopAddr
// as the end-of-benchmark register; otherwise StopAddr is an ordinary address.
module tiny_soc_mem_ctrl #(
    parameter int                   NumPorts    = 2,
    parameter int                   AddrWidth   = 32,
    parameter int                   DataWidth   = 64,
    parameter int                   NumWords    = 1 << 17,
    parameter logic [AddrWidth-1:0] BaseAddr    = AddrWidth'(32'h8000_0000),
    parameter int                   ReadLatency = 1,
    parameter logic [AddrWidth-1:0] StopAddr    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    tiny_soc_mem_ctrl_if.slave    bus,
    output logic                  stop_valid_o,
    output logic [31:0]           stop_code_o
);
    localparam int BeWidth = DataWidth / 8;
    localparam int OffBits = $clog2(BeWidth);
    localparam int PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int IdxW    = (NumWords > 1) ? $clog2(NumWords) : 1;

    localparam logic [PtrW:0]        NumPortsW = (PtrW + 1)'(NumPorts);
    localparam logic [PtrW-1:0]      LastPort  = PtrW'(NumPorts - 1);
    localparam logic [AddrWidth-1:0] NumWordsW = AddrWidth'(NumWords);

    // ---------------- round-robin arbiter ----------------
    logic [PtrW-1:0]     ptr_q;
    logic [PtrW-1:0]     win;
    logic [PtrW:0]       cand_sum;
    logic [PtrW-1:0]     cand;
    logic [NumPorts-1:0] gnt;
    logic                gnt_any;

    // Search starts at the pointer and wraps; grants are suppressed while in reset.
    always_comb begin
        gnt      = '0;
        win      = '0;
        gnt_any  = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand_sum = {1'b0, ptr_q} + (PtrW + 1)'(i);
            if (cand_sum >= NumPortsW) begin
                cand_sum = cand_sum - NumPortsW;
            end
            cand = cand_sum[PtrW-1:0];
            if (rst_ni && !gnt_any && bus.req_i[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                win       = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (win == LastPort) ? '0 : win + 1'b1;
        end
    end

    // ---------------- granted request mux and decode ----------------
    logic                 g_we;
    logic [AddrWidth-1:0] g_addr;
    logic [BeWidth-1:0]   g_be;
    logic [DataWidth-1:0] g_wdata;
    logic [AddrWidth-1:0] word_full;
    logic [IdxW-1:0]      mem_idx;
    logic                 stop_hit;
    logic                 in_range;
    logic                 access_err;
    logic                 mem_we;
    logic                 keep_d;

    assign g_we    = bus.we_i[win];
    assign g_addr  = bus.addr_i[int'(win)*AddrWidth +: AddrWidth];
    assign g_be    = bus.be_i[int'(win)*BeWidth +: BeWidth];
    assign g_wdata = bus.wdata_i[int'(win)*DataWidth +: DataWidth];

    // Unsigned offset; addresses below BaseAddr wrap high and fail the index test
    // as well, but the explicit >= keeps the intent obvious. Low bits drop out here.
    assign word_full = (g_addr - BaseAddr) >> OffBits;
    assign mem_idx   = word_full[IdxW-1:0];
    assign in_range  = !stop_hit && (g_addr >= BaseAddr) && (word_full < NumWordsW);

    assign access_err = gnt_any && !stop_hit && !in_range;
    assign mem_we     = gnt_any && g_we && in_range;
    assign keep_d     = gnt_any && !g_we && in_range;

`ifdef TINY_SOC_MMIO_STOP_EN
    localparam logic [AddrWidth-1:0] StopWord = StopAddr >> OffBits;

    logic        stop_valid_q;
    logic [31:0] stop_code_q;

    assign stop_hit = gnt_any && g_we && ((g_addr >> OffBits) == StopWord);

    // First stop write wins; later ones still get a clean response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stop_valid_q <= 1'b0;
            stop_code_q  <= '0;
        end else if (stop_hit && !stop_valid_q) begin
            stop_valid_q <= 1'b1;
            stop_code_q  <= g_wdata[31:0];
        end
    end

    assign stop_valid_o = stop_valid_q;
    assign stop_code_o  = stop_code_q;
`else
    assign stop_hit     = 1'b0;
    assign stop_valid_o = 1'b0;
    assign stop_code_o  = '0;
`endif

    // ---------------- SRAM (not reset) ----------------
    logic [DataWidth-1:0] mem [NumWords];
    logic [DataWidth-1:0] rd_q;

    // Read-before-write on the same edge: a read sees every write granted earlier.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (g_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
                end
            end
        end
        rd_q <= mem[mem_idx];
    end

    // ---------------- response pipeline ----------------
    logic [ReadLatency-1:0] vld_q;
    logic [ReadLatency-1:0] err_q;
    logic [NumPorts-1:0]    port_q [ReadLatency];
    logic                   keep_q;
    logic [DataWidth-1:0]   stage0_data;
    logic [DataWidth-1:0]   out_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            err_q  <= '0;
            keep_q <= 1'b0;
            for (int k = 0; k < ReadLatency; k++) begin
                port_q[k] <= '0;
            end
        end else begin
            vld_q[0]  <= gnt_any;
            err_q[0]  <= access_err;
            port_q[0] <= gnt;
            keep_q    <= keep_d;
            for (int k = 1; k < ReadLatency; k++) begin
                vld_q[k]  <= vld_q[k-1];
                err_q[k]  <= err_q[k-1];
                port_q[k] <= port_q[k-1];
            end
        end
    end

    // Writes, errors and stop accesses return zero data.
    assign stage0_data = keep_q ? rd_q : '0;

    generate
        if (ReadLatency == 1) begin : g_lat1
            assign out_data = stage0_data;
        end else begin : g_latn
            logic [DataWidth-1:0] dpipe_q [ReadLatency-1];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 0; k < ReadLatency - 1; k++) begin
                        dpipe_q[k] <= '0;
                    end
                end else begin
                    dpipe_q[0] <= stage0_data;
                    for (int k = 1; k < ReadLatency - 1; k++) begin
                        dpipe_q[k] <= dpipe_q[k-1];
                    end
                end
            end

            assign out_data = dpipe_q[ReadLatency-2];
        end
    endgenerate

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = vld_q[ReadLatency-1] ? port_q[ReadLatency-1] : '0;
    assign bus.err_o    = (vld_q[ReadLatency-1] && err_q[ReadLatency-1]) ? port_q[ReadLatency-1] : '0;
    assign bus.rdata_o  = vld_q[ReadLatency-1] ? out_data : '0;
endmodule

// File: tb/tb_tiny_soc_mem_ctrl.sv
// tb/tb_tiny_soc_mem_ctrl.sv - self-checking bench for tiny_soc_mem_ctrl
module tb_tiny_soc_mem_ctrl;
    localparam int          N    = 2;
    localparam int          AW   = 32;
    localparam int          DW   = 64;
    localparam int          NW   = 1 << 17;
    localparam int          NW3  = 16;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] STOP = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst3_n;
    logic        stop_valid;
    logic        stop_valid3;
    logic [31:0] stop_code;
    logic [31:0] stop_code3;

    tiny_soc_mem_ctrl_if #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW)) bus ();
    tiny_soc_mem_ctrl_if #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW)) bus3 ();

    tiny_soc_mem_ctrl #(
        .NumPorts(N), .AddrWidth(AW), .DataWidth(DW), .NumWords(NW),
        .BaseAddr(BASE), .ReadLatency(1), .StopAddr(STOP)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave),
        .stop_valid_o(stop_valid), .stop_code_o(stop_code)
    );

    tiny_soc_mem_ctrl #(
        .NumPorts(N), .AddrWidth(AW), .DataWidth(DW), .NumWords(NW3),
        .BaseAddr(BASE), .ReadLatency(3), .StopAddr(STOP)
    ) u_dut3 (
        .clk_i(clk), .rst_ni(rst3_n), .bus(bus3.slave),
        .stop_valid_o(stop_valid3), .stop_code_o(stop_code3)
    );

    typedef struct {
        int          port;
        logic        err;
        logic [63:0] data;
        int          due;
    } resp_t;

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          ptr        = 0;
    logic [N-1:0] p_req;
    logic [N-1:0] p_we;
    logic [31:0] p_addr  [N];
    logic [7:0]  p_be    [N];
    logic [63:0] p_wdata [N];
    logic [63:0] model_mem [int];
    resp_t       rq [$];
    logic        exp_stop_valid = 1'b0;
    logic [31:0] exp_stop_code  = '0;
    logic [N-1:0] last_gnt;
    logic [N-1:0] last_rvalid;
    logic [N-1:0] last_err;
    logic [63:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.req_i = p_req;
        bus.we_i  = p_we;
        for (int p = 0; p < N; p++) begin
            bus.addr_i[p*AW +: AW]   = p_addr[p];
            bus.be_i[p*8 +: 8]       = p_be[p];
            bus.wdata_i[p*DW +: DW]  = p_wdata[p];
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] addr,
                         input logic [7:0] be, input logic [63:0] wdata);
        p_req[p]   = 1'b1;
        p_we[p]    = we;
        p_addr[p]  = addr;
        p_be[p]    = be;
        p_wdata[p] = wdata;
    endtask

    // One clock of the main DUT: predict the grant and its response, then
    // step to the next falling edge and compare whatever response is due.
    task automatic cycle();
        int          w;
        int          idx;
        logic [N-1:0] eg;
        logic [63:0] a;
        logic [63:0] word;
        logic        is_stop;
        resp_t       r;
        apply();
        #1;
        w = -1;
        for (int i = 0; i < N; i++) begin
            if (w < 0 && p_req[(ptr + i) % N]) w = (ptr + i) % N;
        end
        eg = (w >= 0) ? (N'(1) << w) : '0;
        last_gnt = bus.gnt_o;
        check("gnt", bus.gnt_o, eg);
        if (w >= 0) begin
            ptr    = (w + 1) % N;
            a      = {32'h0, p_addr[w]};
            r.port = w;
            r.err  = 1'b0;
            r.data = '0;
            r.due  = cyc + 1;
            is_stop = 1'b0;
`ifdef TINY_SOC_MMIO_STOP_EN
            is_stop = p_we[w] && ((a >> 3) == ({32'h0, STOP} >> 3));
`endif
            if (is_stop) begin
                if (!exp_stop_valid) begin
                    exp_stop_valid = 1'b1;
                    exp_stop_code  = p_wdata[w][31:0];
                end
            end else if (a < {32'h0, BASE} || ((a - {32'h0, BASE}) >> 3) >= NW) begin
                r.err = 1'b1;
            end else begin
                idx = int'((a - {32'h0, BASE}) >> 3);
                if (p_we[w]) begin
                    word = model_mem.exists(idx) ? model_mem[idx] : 64'h0;
                    for (int b = 0; b < 8; b++) begin
                        if (p_be[w][b]) word[b*8 +: 8] = p_wdata[w][b*8 +: 8];
                    end
                    model_mem[idx] = word;
                end else begin
                    r.data = model_mem[idx];
                end
            end
            rq.push_back(r);
            p_req[w] = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        last_rvalid = bus.rvalid_o;
        last_err    = bus.err_o;
        last_rdata  = bus.rdata_o;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check("rvalid", bus.rvalid_o, N'(1) << r.port);
            check("err", bus.err_o, r.err ? (N'(1) << r.port) : '0);
            check("rdata", bus.rdata_o, r.data);
        end else begin
            check("rvalid_idle", bus.rvalid_o, '0);
        end
        check("stop_valid", stop_valid, exp_stop_valid);
        check("stop_code", stop_code, exp_stop_code);
    endtask

    initial begin
        int nextw;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        p_req  = '0;
        p_we   = '0;
        for (int p = 0; p < N; p++) begin
            p_addr[p] = '0; p_be[p] = '0; p_wdata[p] = '0;
        end
        bus3.req_i = '0; bus3.we_i = '0; bus3.addr_i = '0; bus3.be_i = '0; bus3.wdata_i = '0;

        // Reset state, with requests pending on both ports.
        issue(0, 1'b0, BASE, 8'hFF, 64'h0);
        issue(1, 1'b1, BASE + 8, 8'hFF, 64'h1);
        apply();
        repeat (2) @(negedge clk);
        check("rst_gnt", bus.gnt_o, '0);
        check("rst_rvalid", bus.rvalid_o, '0);
        check("rst_err", bus.err_o, '0);
        check("rst_rdata", bus.rdata_o, '0);
        check("rst_stop_valid", stop_valid, 1'b0);
        check("rst_stop_code", stop_code, '0);
        p_req = '0;
        apply();
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);

        // Both ports requesting continuously: grants alternate from port 0.
        nextw = 0;
        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < N; p++) begin
                if (!p_req[p]) begin
                    issue(p, 1'b1, BASE + 32'(nextw * 8), 8'hFF, {$urandom, $urandom});
                    nextw++;
                end
            end
            cycle();
            check("rr_seq", last_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        repeat (2) cycle();

        // Full write then read back on port 0.
        issue(0, 1'b1, 32'h8000_0008, 8'hFF, 64'h1122334455667788);
        cycle();
        check("wr_resp_rdata", last_rdata, 64'h0);
        issue(0, 1'b0, 32'h8000_0008, 8'h00, 64'h0);
        cycle();
        check("rd_rvalid", last_rvalid, 2'b01);
        check("rd_err", last_err, 2'b00);
        check("rd_rdata", last_rdata, 64'h1122334455667788);

        // Partial byte-strobe write.
        issue(0, 1'b1, 32'h8000_0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        cycle();
        issue(0, 1'b0, 32'h8000_000C, 8'h00, 64'h0);
        cycle();
        check("be_rdata", last_rdata, 64'h11223344_BBBBBBBB);

        // Out-of-range accesses on both sides of the window.
        issue(1, 1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0);
        cycle();
        check("oor_lo_err", last_err, 2'b10);
        check("oor_lo_rdata", last_rdata, 64'h0);
        issue(1, 1'b0, BASE + 32'(NW * 8), 8'h00, 64'h0);
        cycle();
        check("oor_hi_err", last_err, 2'b10);
        issue(0, 1'b1, BASE + 32'(NW * 8), 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        cycle();
        issue(0, 1'b1, 32'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        cycle();
        issue(0, 1'b0, BASE, 8'h00, 64'h0);
        cycle();
        issue(0, 1'b0, 32'h8000_0008, 8'h00, 64'h0);
        cycle();
        check("oor_unchanged", last_rdata, 64'h11223344_BBBBBBBB);

        // End-of-benchmark register.
        issue(0, 1'b1, 32'h0000_0000, 8'hFF, 64'h1);
        cycle();
`ifdef TINY_SOC_MMIO_STOP_EN
        check("stop1_err", last_err, 2'b00);
        check("stop1_valid", stop_valid, 1'b1);
`else
        check("stop1_err", last_err, 2'b01);
        check("stop1_valid", stop_valid, 1'b0);
`endif
        issue(0, 1'b1, 32'h0000_0004, 8'hFF, 64'h5);
        cycle();
`ifdef TINY_SOC_MMIO_STOP_EN
        check("stop2_code", stop_code, 32'h1);
`else
        check("stop2_code", stop_code, 32'h0);
`endif

        // Randomized traffic over words 0..7, misaligned offsets, occasional out-of-range.
        issue(1, 1'b1, BASE + 32'd56, 8'hFF, {$urandom, $urandom});
        cycle();
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < N; p++) begin
                if (!p_req[p] && $urandom_range(0, 9) < 7) begin
                    logic [31:0] addr;
                    addr = BASE + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 15) == 0) addr = BASE - 32'($urandom_range(1, 4) * 8);
                    if ($urandom_range(0, 15) == 0) addr = BASE + 32'(NW * 8) + 32'($urandom_range(0, 63));
                    issue(p, 1'($urandom_range(0, 1)), addr, 8'($urandom), {$urandom, $urandom});
                end
            end
            cycle();
        end
        p_req = '0;
        repeat (3) cycle();
        check("drain_empty", 64'(rq.size()), 64'h0);

        // ReadLatency=3 instance: exact latency for write then read.
        @(negedge clk);
        bus3.req_i = 2'b01; bus3.we_i = 2'b01; bus3.addr_i[31:0] = BASE + 32'd16;
        bus3.be_i[7:0] = 8'hFF; bus3.wdata_i[63:0] = 64'hCAFE_F00D_0123_4567;
        #1;
        check("l3_wr_gnt", bus3.gnt_o, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus3.req_i = '0;
            check("l3_wr_rvalid", bus3.rvalid_o, (k == 3) ? 2'b01 : 2'b00);
        end
        bus3.req_i = 2'b01; bus3.we_i = 2'b00;
        #1;
        check("l3_rd_gnt", bus3.gnt_o, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus3.req_i = '0;
            check("l3_rd_rvalid", bus3.rvalid_o, (k == 3) ? 2'b01 : 2'b00);
            if (k == 3) check("l3_rd_rdata", bus3.rdata_o, 64'hCAFE_F00D_0123_4567);
        end

        // Reset one cycle after a read grant flushes the in-flight response.
        bus3.req_i = 2'b01;
        #1;
        check("l3_flush_gnt", bus3.gnt_o, 2'b01);
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        check("l3_rst_gnt", bus3.gnt_o, 2'b00);
        check("l3_rst_rvalid", bus3.rvalid_o, 2'b00);
        repeat (2) @(negedge clk);
        bus3.req_i = '0;
        rst3_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("l3_post_rst_rvalid", bus3.rvalid_o, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
